rx_ctrl_fsm: RTL and testbench

// - Serial receive control FSM; drives clear/count_enable of two flex_counter instances, consumes their rollover flags.
//   - Bit-period timer: rollover_flag = mid-bit tick.
//   - Data-bit counter: rollover_flag = all data bits shifted.
// - Detects start bit, sequences data shifting, checks stop bit(s), loads the output buffer.
// - Maintains data_ready / framing_error / overrun_error status.

---
 rtl/rx_ctrl_fsm.sv | 151 +++++++++++++++
 tb/tb_rx_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl_fsm.sv
// Serial receive control FSM driving a bit-period timer and a data-bit counter.
// Optional 2-of-3 majority line filter enabled by defining RX_GLITCH_FILTER_EN.
module rx_ctrl_fsm #(
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic bit_tick,
  input  logic bits_done,
  input  logic data_read,
  output logic timer_clear,
  output logic timer_enable,
  output logic bitcnt_clear,
  output logic bitcnt_enable,
  output logic shift_enable,
  output logic load_buffer,
  output logic busy,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

  localparam logic [1:0] STOP_N = 2'(STOP_BITS);

  state_t     state_q, state_d;
  logic [1:0] stop_cnt_q, stop_cnt_d;
  logic       prev_rx_q, prev_rx_d;
  logic       data_ready_q, data_ready_d;
  logic       framing_q, framing_d;
  logic       overrun_q, overrun_d;
  logic       rx, fall;

`ifdef RX_GLITCH_FILTER_EN
  logic [2:0] samp_q, samp_d;

  assign samp_d = {samp_q[1:0], serial_in};
  // 2-of-3 vote: a single-cycle excursion never wins a majority
  assign rx = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) samp_q <= 3'b111;
    else     samp_q <= samp_d;
  end
`else
  assign rx = serial_in;
`endif

  assign fall      = prev_rx_q & ~rx;
  assign prev_rx_d = rx;

  always_comb begin
    state_d       = state_q;
    stop_cnt_d    = stop_cnt_q;
    data_ready_d  = data_ready_q;
    framing_d     = framing_q;
    overrun_d     = overrun_q;
    timer_clear   = 1'b0;
    timer_enable  = 1'b0;
    bitcnt_clear  = 1'b0;
    bitcnt_enable = 1'b0;
    shift_enable  = 1'b0;
    load_buffer   = 1'b0;

    if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          timer_clear  = 1'b1;
          bitcnt_clear = 1'b1;
          framing_d    = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        timer_enable = 1'b1;
        if (bit_tick) state_d = rx ? IDLE : DATA;
      end
      DATA: begin
        timer_enable = 1'b1;
        if (bits_done) begin
          state_d    = STOP;
          stop_cnt_d = 2'd0;
        end else if (bit_tick) begin
          shift_enable  = 1'b1;
          bitcnt_enable = 1'b1;
        end
      end
      STOP: begin
        timer_enable = 1'b1;
        if (bit_tick) begin
          if (!rx) begin
            framing_d = 1'b1;
            state_d   = IDLE;
          end else if (stop_cnt_q + 2'd1 == STOP_N) begin
            state_d = LOAD;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
      end
      LOAD: begin
        load_buffer  = 1'b1;
        data_ready_d = 1'b1;
        if (data_ready_q && !data_read) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // strobes stay quiet while reset is held, even if the line is low
    if (rst) begin
      timer_clear   = 1'b0;
      timer_enable  = 1'b0;
      bitcnt_clear  = 1'b0;
      bitcnt_enable = 1'b0;
      shift_enable  = 1'b0;
      load_buffer   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stop_cnt_q   <= 2'd0;
      prev_rx_q    <= 1'b1;
      data_ready_q <= 1'b0;
      framing_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stop_cnt_q   <= stop_cnt_d;
      prev_rx_q    <= prev_rx_d;
      data_ready_q <= data_ready_d;
      framing_q    <= framing_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign data_ready    = data_ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// Scoreboard bench for rx_ctrl_fsm: instance 0 uses one stop bit, instance 1 uses two.
// Behavioural timer/bit counters close the loop around each instance.
module tb_rx_ctrl_fsm;
`ifdef RX_GLITCH_FILTER_EN
  localparam int FLT = 2;
`else
  localparam int FLT = 0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic       serial_in;
  logic [1:0] bit_tick, bits_done, data_read;
  logic [1:0] timer_clear, timer_enable, bitcnt_clear, bitcnt_enable;
  logic [1:0] shift_enable, load_buffer, busy, data_ready, framing_error, overrun_error;

  rx_ctrl_fsm #(.STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst[0]), .serial_in(serial_in), .bit_tick(bit_tick[0]),
    .bits_done(bits_done[0]), .data_read(data_read[0]), .timer_clear(timer_clear[0]),
    .timer_enable(timer_enable[0]), .bitcnt_clear(bitcnt_clear[0]),
    .bitcnt_enable(bitcnt_enable[0]), .shift_enable(shift_enable[0]),
    .load_buffer(load_buffer[0]), .busy(busy[0]), .data_ready(data_ready[0]),
    .framing_error(framing_error[0]), .overrun_error(overrun_error[0]));

  rx_ctrl_fsm #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst[1]), .serial_in(serial_in), .bit_tick(bit_tick[1]),
    .bits_done(bits_done[1]), .data_read(data_read[1]), .timer_clear(timer_clear[1]),
    .timer_enable(timer_enable[1]), .bitcnt_clear(bitcnt_clear[1]),
    .bitcnt_enable(bitcnt_enable[1]), .shift_enable(shift_enable[1]),
    .load_buffer(load_buffer[1]), .busy(busy[1]), .data_ready(data_ready[1]),
    .framing_error(framing_error[1]), .overrun_error(overrun_error[1]));

  // timer ticks at count 7 (mid-bit), wraps every 16; bit counter done at 8
  logic [1:0][3:0] tcnt = '0;
  logic [1:0][3:0] bcnt = '0;
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (timer_clear[g])        tcnt[g] <= 4'd0;
      else if (timer_enable[g])  tcnt[g] <= tcnt[g] + 4'd1;
      if (bitcnt_clear[g])       bcnt[g] <= 4'd0;
      else if (bitcnt_enable[g]) bcnt[g] <= bcnt[g] + 4'd1;
    end
  end
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      bit_tick[g]  = timer_enable[g] && (tcnt[g] == 4'd7);
      bits_done[g] = (bcnt[g] == 4'd8);
    end
  end

  // data shift register model for instance 0, sampling the raw line
  logic [7:0] shreg = '0;
  int nshift = 0, shift_tot = 0, loads2 = 0;
  always @(posedge clk) begin
    if (timer_clear[0]) nshift <= 0;
    else if (shift_enable[0]) begin
      shreg  <= {serial_in, shreg[7:1]};
      nshift <= nshift + 1;
    end
    if (shift_enable[0]) shift_tot <= shift_tot + 1;
    if (load_buffer[1])  loads2 <= loads2 + 1;
  end

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // monitor: every load or new framing error on instance 0 consumes one expectation
  initial begin
    exp_t e;
    logic ferr_prev;
    ferr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (load_buffer[0]) begin
        if (sbq.size() == 0) chk("sb_unexpected_load", int'(shreg), -1);
        else begin
          e = sbq.pop_front();
          chk("sb_load_kind", int'(e.ferr), 0);
          chk("sb_data", int'(shreg), int'(e.data));
          chk("sb_nshift", nshift, 8);
        end
      end
      if (framing_error[0] && !ferr_prev) begin
        if (sbq.size() == 0) chk("sb_unexpected_ferr", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("sb_ferr_kind", int'(e.ferr), 1);
        end
      end
      ferr_prev = framing_error[0];
    end
  end

  task automatic send(input int u, input logic [7:0] d, input logic s1, input logic s2,
                      input int nstop);
    serial_in = 1'b0;
    repeat (FLT) @(negedge clk);
    chk("start_latency_pre", int'(busy[u]), 0);
    @(negedge clk);
    chk("start_latency", int'(busy[u]), 1);
    chk("start_clears_ferr", int'(framing_error[u]), 0);
    repeat (15 - FLT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (16) @(negedge clk);
    end
    serial_in = s1;
    repeat (16) @(negedge clk);
    if (nstop == 2) begin
      serial_in = s2;
      repeat (16) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic pulse_read(input int u);
    data_read[u] = 1'b1;
    @(negedge clk);
    data_read[u] = 1'b0;
  endtask

  initial begin
    int  t0;
    bit  saw_busy;
    serial_in = 1'b1;
    rst       = 2'b11;
    data_read = 2'b00;
    repeat (3) @(negedge clk);
    serial_in = 1'b0;
    @(negedge clk);
    chk("reset_outputs", int'({timer_clear[0], timer_enable[0], bitcnt_clear[0],
        bitcnt_enable[0], shift_enable[0], load_buffer[0], busy[0], data_ready[0],
        framing_error[0], overrun_error[0]}), 0);
    serial_in = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (4) @(negedge clk);

    // good frame 0xA5
    sbq.push_back('{1'b0, 8'hA5});
    send(0, 8'hA5, 1'b1, 1'b1, 1);
    chk("a5_data_ready", int'(data_ready[0]), 1);
    chk("a5_ferr", int'(framing_error[0]), 0);
    chk("a5_shift_total", shift_tot, 8);
    pulse_read(0);
    chk("read_clears_ready", int'(data_ready[0]), 0);

    // false start: low for 4 clk, back high before the start tick
    t0 = shift_tot;
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("false_start_idle", int'(busy[0]), 0);
    chk("false_start_no_shift", shift_tot - t0, 0);
    chk("false_start_flags", int'({data_ready[0], framing_error[0], overrun_error[0]}), 0);

    // single-clock glitch on the idle line
    t0 = shift_tot;
    saw_busy = 1'b0;
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    repeat (24) begin
      @(negedge clk);
      if (busy[0]) saw_busy = 1'b1;
    end
`ifdef RX_GLITCH_FILTER_EN
    chk("glitch_rejected", int'(saw_busy), 0);
`else
    chk("glitch_false_start", int'(saw_busy), 1);
`endif
    chk("glitch_no_shift", shift_tot - t0, 0);
    chk("glitch_idle", int'(busy[0]), 0);

    // reset in the middle of DATA
    serial_in = 1'b0;
    repeat (16) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", int'(busy[0]), 1);
    rst[0] = 1'b1;
    #1;
    chk("mid_reset_outputs", int'({timer_clear[0], timer_enable[0], bitcnt_clear[0],
        bitcnt_enable[0], shift_enable[0], load_buffer[0], busy[0], data_ready[0],
        framing_error[0], overrun_error[0]}), 0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", int'(busy[0]), 0);
    sbq.push_back('{1'b0, 8'h3C});
    send(0, 8'h3C, 1'b1, 1'b1, 1);
    chk("post_reset_ready", int'(data_ready[0]), 1);

    // bad stop bit: no load, ready untouched, error cleared at next start
    sbq.push_back('{1'b1, 8'h00});
    send(0, 8'h5A, 1'b0, 1'b1, 1);
    chk("ferr_set", int'(framing_error[0]), 1);
    chk("ferr_ready_kept", int'(data_ready[0]), 1);
    chk("ferr_no_overrun", int'(overrun_error[0]), 0);
    pulse_read(0);
    chk("read_keeps_ferr", int'(framing_error[0]), 1);
    chk("read_clears_ready2", int'(data_ready[0]), 0);

    // overrun: two good frames without a read
    sbq.push_back('{1'b0, 8'h81});
    send(0, 8'h81, 1'b1, 1'b1, 1);
    chk("ovr_first_ready", int'(data_ready[0]), 1);
    chk("ovr_first_clear", int'(overrun_error[0]), 0);
    sbq.push_back('{1'b0, 8'h7E});
    send(0, 8'h7E, 1'b1, 1'b1, 1);
    chk("ovr_set", int'(overrun_error[0]), 1);
    chk("ovr_ready", int'(data_ready[0]), 1);
    pulse_read(0);
    chk("ovr_read_clears", int'({data_ready[0], overrun_error[0]}), 0);
    chk("sb_empty", sbq.size(), 0);

    // two stop bits on the second instance
    rst = 2'b01;
    repeat (4) @(negedge clk);
    send(1, 8'hC3, 1'b1, 1'b0, 2);
    chk("stop2_ferr", int'(framing_error[1]), 1);
    chk("stop2_no_ready", int'(data_ready[1]), 0);
    chk("stop2_no_load", loads2, 0);
    send(1, 8'h42, 1'b1, 1'b1, 2);
    chk("stop2_good_ready", int'(data_ready[1]), 1);
    chk("stop2_good_ferr", int'(framing_error[1]), 0);
    chk("stop2_one_load", loads2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
